// File: rtl/sprite_mover.sv
// Horizontal sprite X-position generator with wrap/bounce edges, blinking respawn and freeze.
// Optional feature macro: SPRITE_BOUNCE_EN (bounce mode with direction inversion).
module sprite_mover #(
    parameter int WIDTH         = 10,
    parameter int START_X       = 40,
    parameter int MIN_X         = 10,
    parameter int MAX_X         = 600,
    parameter int STEP_W        = 4,
    parameter int RESPAWN_TICKS = 30,
    parameter int BLINK_TICKS   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              col,
    input  logic              finish,
    input  logic [STEP_W-1:0] step,
    input  logic              dir_left,
    input  logic              mode,
    output logic [WIDTH-1:0]  pos_x,
    output logic              moving_left,
    output logic              visible,
    output logic              respawning,
    output logic              edge_evt
);

    localparam int CMAX = (RESPAWN_TICKS > BLINK_TICKS) ? RESPAWN_TICKS : BLINK_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [WIDTH-1:0] START_P = WIDTH'(START_X);
    localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_X);
    localparam logic [WIDTH-1:0] LAST_P  = WIDTH'(MAX_X - 1);
    localparam logic [WIDTH:0]   MIN_N   = (WIDTH+1)'(MIN_X);
    localparam logic [WIDTH:0]   MAX_N   = (WIDTH+1)'(MAX_X);
    localparam logic [CW-1:0]    RESP_C  = CW'(RESPAWN_TICKS);
    localparam logic [CW-1:0]    BLINK_C = CW'(BLINK_TICKS);

    typedef enum logic {RUN, HIT} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;
    logic [WIDTH:0]  next_x;
    logic            over_right;
    logic            under_left;
    logic            blink_wrap;

`ifndef SPRITE_BOUNCE_EN
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // One extra bit so a left move past zero shows up as a set MSB.
    always_comb begin
        next_x     = moving_left ? ({1'b0, pos_x} - (WIDTH+1)'(step))
                                 : ({1'b0, pos_x} + (WIDTH+1)'(step));
        over_right = !moving_left && (next_x >= MAX_N);
        under_left = moving_left && (next_x[WIDTH] || (next_x < MIN_N));
        count_inc  = count + CW'(1);
        blink_wrap = ((count_inc % BLINK_C) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x       <= START_P;
            moving_left <= dir_left;
            visible     <= 1'b1;
            respawning  <= 1'b0;
            edge_evt    <= 1'b0;
            state       <= RUN;
            count       <= '0;
        end else begin
            edge_evt <= 1'b0;
            if (tick && !finish) begin
                case (state)
                    RUN: begin
                        if (col) begin
                            pos_x      <= START_P;
                            state      <= HIT;
                            respawning <= 1'b1;
                            count      <= '0;
                            visible    <= 1'b0;
                        end else if (over_right) begin
                            edge_evt <= 1'b1;
`ifdef SPRITE_BOUNCE_EN
                            if (mode) begin
                                pos_x       <= LAST_P;
                                moving_left <= 1'b1;
                            end else begin
                                pos_x <= MIN_P;
                            end
`else
                            pos_x <= MIN_P;
`endif
                        end else if (under_left) begin
                            edge_evt <= 1'b1;
`ifdef SPRITE_BOUNCE_EN
                            if (mode) begin
                                pos_x       <= MIN_P;
                                moving_left <= 1'b0;
                            end else begin
                                pos_x <= LAST_P;
                            end
`else
                            pos_x <= LAST_P;
`endif
                        end else begin
                            pos_x <= next_x[WIDTH-1:0];
                        end
                    end
                    HIT: begin
                        if (count_inc == RESP_C) begin
                            state       <= RUN;
                            respawning  <= 1'b0;
                            visible     <= 1'b1;
                            moving_left <= dir_left;
                            count       <= '0;
                        end else begin
                            count <= count_inc;
                            if (blink_wrap)
                                visible <= ~visible;
                        end
                    end
                endcase
            end
        end
    end

endmodule
